// File: rtl/adc_spi_responder.sv
// ============================================================================
// Module  : adc_spi_responder
// Brief   : Converter-side responder for the 16-clock ADC SPI frame; serves
//           samples from a parallel channel bank with pipelined addressing.
//           Optional macro ADC_RESP_TEST_PATTERN_EN replaces sample_data with
//           the fixed word {0, channel, 8'hA5}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_spi_responder #(
    parameter int DATA_WIDTH  = 12,
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   sample_data,
    input  logic                           adc_cs_n,
    input  logic                           adc_sclk,
    input  logic                           adc_din,
    output logic                           adc_dout,
    output logic [2:0]                     cur_channel,
    output logic                           frame_done,
    output logic                           frame_abort
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   r_cs_prev;
    logic                   r_sclk_prev;
    logic                   r_cs_armed;

    state_t                 r_state;
    logic [15:0]            r_shift;
    logic [4:0]             r_bit_cnt;
    logic [2:0]             r_cmd_addr;
    logic [2:0]             r_next_addr;
    logic [2:0]             r_cur_channel;
    logic                   r_dout;
    logic                   r_done;
    logic                   r_abort;

    logic                   w_cs;
    logic                   w_sclk;
    logic                   w_din;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic [DATA_WIDTH-1:0]  w_word;
    logic [15:0]            w_frame;
    logic [15:0]            w_shift_next;
    logic                   w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '1;
            r_din_sync  <= '0;
            r_sync_vld  <= '0;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b1;
            r_cs_armed  <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], adc_sclk};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], adc_din};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_cs_prev   <= w_cs;
            r_sclk_prev <= w_sclk;
            // Only a CS fall preceded by a real (pin-derived) high starts a frame,
            // so CS held low across reset release does not look like a fall.
            r_cs_armed  <= r_cs_armed | (r_sync_vld[SYNC_STAGES-1] & w_cs);
        end
    end

    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_din       = r_din_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_prev & ~w_cs;
    assign w_cs_rise   = ~r_cs_prev & w_cs;
    assign w_sclk_rise = ~r_sclk_prev & w_sclk;
    assign w_sclk_fall = r_sclk_prev & ~w_sclk;

`ifdef ADC_RESP_TEST_PATTERN_EN
    assign w_word   = DATA_WIDTH'({1'b0, r_next_addr, 8'hA5});
    assign w_unused = ^{sample_data, r_shift[15]};
`else
    logic [DATA_WIDTH-1:0] w_ch [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_ch[gi] = sample_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_word   = w_ch[r_next_addr];
    assign w_unused = r_shift[15];
`endif

    assign w_frame      = 16'(w_word);
    assign w_shift_next = {r_shift[14:0], 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_cmd_addr    <= '0;
            r_next_addr   <= '0;
            r_cur_channel <= '0;
            r_dout        <= 1'b0;
            r_done        <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_dout <= 1'b0;
                    if (w_cs_fall && r_cs_armed) begin
                        r_state       <= S_SHIFT;
                        r_shift       <= w_frame;
                        r_cur_channel <= r_next_addr;
                        r_bit_cnt     <= '0;
                        r_dout        <= w_frame[15];
                    end
                end
                S_SHIFT: begin
                    if (w_cs_rise) begin
                        r_abort <= 1'b1;
                        r_dout  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_sclk_rise) begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt >= 5'd2 && r_bit_cnt <= 5'd4)
                            r_cmd_addr <= {r_cmd_addr[1:0], w_din};
                        if (r_bit_cnt == 5'd15) begin
                            r_done      <= 1'b1;
                            r_next_addr <= r_cmd_addr;
                            r_dout      <= 1'b0;
                            r_state     <= S_HOLD;
                        end
                    end else if (w_sclk_fall && r_bit_cnt != 5'd0) begin
                        // The fall ahead of the first rise keeps the MSB presented at CS fall.
                        r_shift <= w_shift_next;
                        r_dout  <= w_shift_next[15];
                    end
                end
                S_HOLD: begin
                    r_dout <= 1'b0;
                    if (w_cs_rise)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dout  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_dout    = r_dout;
    assign cur_channel = r_cur_channel;
    assign frame_done  = r_done;
    assign frame_abort = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
// ============================================================================
// Module  : tb_adc_spi_responder
// Brief   : Randomized SPI-master bench for adc_spi_responder with a queue-based
//           scoreboard checked on frame_done / frame_abort.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_spi_responder;

    localparam int C_H = 5;   // SCLK half period in clk cycles

    logic        clk;
    logic        reset;
    logic [95:0] sample_data;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_din;
    logic        adc_dout;
    logic [2:0]  cur_channel;
    logic        frame_done;
    logic        frame_abort;

    adc_spi_responder #(
        .DATA_WIDTH (12),
        .NUM_CH     (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_data(sample_data),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .adc_din    (adc_din),
        .adc_dout   (adc_dout),
        .cur_channel(cur_channel),
        .frame_done (frame_done),
        .frame_abort(frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [15:0] word;
        logic [2:0]  ch;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] bank [8];
    logic [2:0]  ref_next;
    logic [15:0] rx_word;
    int          checks;
    int          failures;
    bit          prev_pulse;

    always_comb begin
        sample_data = '0;
        for (int i = 0; i < 8; i++)
            sample_data[i*12 +: 12] = bank[i];
    end

    function automatic logic [15:0] model_word(input logic [2:0] ch);
`ifdef ADC_RESP_TEST_PATTERN_EN
        return {4'h0, 1'b0, ch, 8'hA5};
`else
        return {4'h0, bank[ch]};
`endif
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One master frame: nrise SCLK cycles, address on rises 3..5, optional
    // mid-frame change of the channel being served.
    task automatic run_frame(input logic [2:0] addr, input int nrise, input bit mid_change);
        exp_t        e;
        logic [2:0]  ch;
        logic [15:0] shreg;
        ch        = ref_next;
        e.is_done = (nrise >= 16);
        e.ch      = ch;
        e.word    = model_word(ch);
        exp_q.push_back(e);
        shreg     = '0;
        adc_cs_n  = 1'b0;
        wait_clk(C_H);
        for (int k = 1; k <= nrise; k++) begin
            adc_sclk = 1'b0;
            adc_din  = (k >= 3 && k <= 5) ? addr[5-k] : 1'($urandom);
            wait_clk(C_H);
            adc_sclk = 1'b1;
            if (k <= 16) begin
                shreg = {shreg[14:0], adc_dout};
                if (k == 16) rx_word = shreg;
            end else begin
                check("dout_after_16", {15'd0, adc_dout}, 16'd0);
            end
            if (mid_change && k == 8) bank[ch] = ~bank[ch];
            wait_clk(C_H);
        end
        adc_cs_n = 1'b1;
        wait_clk(3 * C_H);
        if (nrise >= 16) ref_next = addr;
    endtask

    task automatic reset_mid_frame();
        bank[ref_next] = 12'hFFF;
        adc_cs_n = 1'b0;
        wait_clk(C_H);
        for (int k = 1; k <= 6; k++) begin
            adc_sclk = 1'b0;
            adc_din  = 1'($urandom);
            wait_clk(C_H);
            adc_sclk = 1'b1;
            wait_clk(C_H);
        end
        reset = 1'b1;
        wait_clk(1);
        check("rst_mid_dout", {15'd0, adc_dout}, 16'd0);
        check("rst_mid_done", {15'd0, frame_done}, 16'd0);
        check("rst_mid_abort", {15'd0, frame_abort}, 16'd0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(C_H);
        adc_cs_n = 1'b1;
        wait_clk(3 * C_H);
        ref_next = 3'd0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            prev_pulse <= 1'b0;
        end else begin
            if ((frame_done || frame_abort) && prev_pulse)
                check("pulse_width", 16'd1, 16'd0);
            prev_pulse <= frame_done | frame_abort;
            if (frame_done || frame_abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {14'd0, frame_done, frame_abort}, 16'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", {15'd0, frame_done}, {15'd0, e.is_done});
                    if (e.is_done) check("frame_word", rx_word, e.word);
                    check("cur_channel", {13'd0, cur_channel}, {13'd0, e.ch});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        ref_next   = 3'd0;
        rx_word    = '0;
        prev_pulse = 1'b0;
        for (int i = 0; i < 8; i++) bank[i] = 12'($urandom);
        reset    = 1'b1;
        adc_cs_n = 1'b1;
        adc_sclk = 1'b1;
        adc_din  = 1'b0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(1);
        check("reset_dout", {15'd0, adc_dout}, 16'd0);
        check("reset_cur_channel", {13'd0, cur_channel}, 16'd0);
        check("reset_done", {15'd0, frame_done}, 16'd0);
        check("reset_abort", {15'd0, frame_abort}, 16'd0);
        wait_clk(10);

        bank[0] = 12'h123;
        run_frame(3'b011, 16, 1'b0);
        bank[3] = 12'hABC;
        run_frame(3'b111, 16, 1'b0);
        run_frame(3'b010, 7, 1'b0);
        bank[7] = 12'h0F0;
        run_frame(3'b100, 16, 1'b1);
        run_frame(3'b101, 20, 1'b0);
        run_frame(3'b110, 16, 1'b0);

        for (int n = 0; n < 24; n++) begin
            int r;
            int len;
            for (int i = 0; i < 8; i++) bank[i] = 12'($urandom);
            r = $urandom_range(0, 9);
            if (r < 2)      len = $urandom_range(1, 15);
            else if (r < 4) len = $urandom_range(17, 20);
            else            len = 16;
            run_frame(3'($urandom), len, (r == 9));
        end

        reset_mid_frame();
        run_frame(3'b001, 16, 1'b0);
        run_frame(3'b000, 16, 1'b0);

        wait_clk(20);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adc_spi_responder.md
# adc_spi_responder

Serial-side responder for the 8-channel, 12-bit ADC link: it plays the converter end of the 16-clock SPI frame that our ADC master drives on ADC_CS_N/ADC_SCLK/ADC_DIN, and returns samples on ADC_DOUT. It lets the dance-pad/arrow logic be exercised without the physical converter, serving either a simulation bench or an on-board loopback. Sample values come from a parallel channel bank supplied by the surrounding design.

## Interface
- DATA_WIDTH, 12: sample width; must be ≤16; frame carries 16−DATA_WIDTH leading zeros.
- NUM_CH, 8: channel count; fixed 3-bit address.
- SYNC_STAGES, 2: synchronizer depth on cs_n/sclk/din; minimum 2.

Ports:
- clk  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high.
- sample_data  in  NUM_CH*DATA_WIDTH  channel bank; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- adc_cs_n  in  1  frame select from master, active low, asynchronous to clk.
- adc_sclk  in  1  serial clock from master, idles high, asynchronous to clk.
- adc_din  in  1  command bits from master.
- adc_dout  out  1  serial sample data to master.
- cur_channel  out  3  channel being transmitted in the current/last frame.
- frame_done  out  1  one-cycle pulse on a completed 16-clock frame.
- frame_abort  out  1  one-cycle pulse when CS rises before 16 SCLK rising edges.

## Operation
- cs_n, sclk, din pass through SYNC_STAGES flops; all decisions use synchronized copies. SCLK rise/fall detected from the last two synchronized samples.
- Registers: next_addr (3b, channel for next frame), shift (16b), bit_cnt (5b), state.
- States: IDLE, SHIFT, HOLD.
  - IDLE: adc_dout=0. On synchronized CS falling → SHIFT; shift ← {zeros, sample_data[next_addr]}; cur_channel ← next_addr; bit_cnt ← 0; adc_dout ← shift MSB.
  - SHIFT, SCLK rising: bit_cnt+1; if bit_cnt (pre-increment) ∈ {2,3,4}, din is shifted into cmd_addr MSB-first (ADD2, ADD1, ADD0).
  - SHIFT, SCLK falling: shift left by one, zero-fill; adc_dout ← new MSB. Falling edges after the 16th rising edge are ignored.
  - SHIFT, 16th rising edge: frame_done pulse; next_addr ← cmd_addr; → HOLD.
  - HOLD: adc_dout=0; extra SCLK edges ignored; CS rising → IDLE.
  - SHIFT, CS rising before 16th rising edge: frame_abort pulse; next_addr unchanged; → IDLE.
- Sample data is captured at CS fall only; sample_data changes mid-frame have no effect on the current frame.
- Simultaneous CS rising and SCLK edge in the same cycle: CS wins (no count, no shift).
- CS falling while in HOLD is impossible (CS is high before any fall); CS low at reset exit stays in IDLE until a genuine falling edge is seen.

## Timing
- Reset: adc_dout=0, cur_channel=0, frame_done=0, frame_abort=0, next_addr=0, state IDLE, synchronizers cleared to cs_n=1, sclk=1.
- Input-to-action latency: SYNC_STAGES+1 clk cycles after a pin edge.
- adc_dout changes SYNC_STAGES+1 cycles after SCLK falling; master samples on SCLK rising.
- SCLK high and low phases must each be ≥ SYNC_STAGES+2 clk cycles; CS setup to first SCLK fall ≥ same.
- frame_done asserts SYNC_STAGES+1 cycles after the 16th SCLK rising pin edge, width 1 cycle.
- Pipelined addressing: the channel commanded in frame N is returned in frame N+1; frame 0 after reset returns channel 0.

## Configuration
- ADC_RESP_TEST_PATTERN_EN defined: sample_data is ignored; the captured word is {1'b0, channel[2:0], 8'hA5} (DATA_WIDTH=12), e.g. channel 5 → 12'h5A5.
- Not defined: the captured word comes from sample_data as above; the pattern logic is absent.

## Test plan
- Reset, then frame with din address 3'b011, sample_data ch0=12'h123 → adc_dout bits 0000_0001_0010_0011, cur_channel=0, frame_done one pulse, next_addr=3.
- Second frame with address 3'b111, ch3=12'hABC → returns 0000_1010_1011_1100, cur_channel=3.
- Abort: CS rises after 7 SCLK rising edges → frame_abort one pulse, no frame_done, next frame still returns previously commanded channel.
- Change sample_data for the active channel from 12'h0F0 to 12'hF0F mid-frame → frame still returns 12'h0F0.
- Send 20 SCLKs within one CS low → frame_done once at the 16th, adc_dout=0 for clocks 17–20, next_addr from clocks 3–5 only.
- With ADC_RESP_TEST_PATTERN_EN, address channel 6 → following frame returns 12'h6A5; assert reset mid-frame → adc_dout=0 and IDLE on the next cycle, no pulses, next frame returns channel 0.
